bin_to_bcd_seq: RTL

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq_if.sv | 27 ++
 rtl/bin_to_bcd_seq.sv | 126 ++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for the sequential 14-bit binary to 4-digit BCD converter.
interface bin_to_bcd_seq_if;
  logic        start;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic        ovf;

  modport master (
    output start,
    output bin,
    input  bcd,
    input  busy,
    input  done,
    input  ovf
  );

  modport slave (
    input  start,
    input  bin,
    output bcd,
    output busy,
    output done,
    output ovf
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: 14-bit binary to 4 packed BCD digits, one bit per cycle.
// Operands above 9999 skip the shift phase and report a saturated 9999 with ovf set.
module bin_to_bcd_seq (
  input logic             clk,
  input logic             Clr,
  bin_to_bcd_seq_if.slave bus
);

  localparam int unsigned BinW = 14;
  localparam int unsigned BcdW = 16;
  localparam int unsigned ShW  = BinW + BcdW;

  localparam logic [BinW-1:0] MaxIn    = 14'd9999;
  localparam logic [BcdW-1:0] SatValue = 16'h9999;
  localparam logic [3:0]      Steps    = 4'd14;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [ShW-1:0]  sh_q, sh_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [BcdW-1:0] bcd_q, bcd_d;
  logic            ovf_q, ovf_d;

  logic [BcdW-1:0] adj;
  logic [ShW-1:0]  stepped;
  logic            unused_adj_msb;

  // Add 3 to every digit >= 5 so the following shift carries correctly into the next digit.
  function automatic logic [BcdW-1:0] dabble_adj(input logic [BcdW-1:0] d);
    logic [BcdW-1:0] r;
    r = d;
    for (int i = 0; i < 4; i++) begin
      if (d[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = d[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  always_comb begin
    adj     = dabble_adj(sh_q[ShW-1:BinW]);
    stepped = {adj[BcdW-2:0], sh_q[BinW-1:0], 1'b0};
  end

  // The digit MSB shifted out is always zero for operands <= 9999.
  assign unused_adj_msb = adj[BcdW-1];

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.bin > MaxIn) begin
            state_d = StDone;
            bcd_d   = SatValue;
            ovf_d   = 1'b1;
          end else begin
            state_d = StShift;
            sh_d    = {{BcdW{1'b0}}, bus.bin};
            cnt_d   = Steps;
          end
        end
      end

      StShift: begin
        sh_d  = stepped;
        cnt_d = cnt_q - 4'd1;
        // Results are latched on the edge entering DONE so they are valid alongside done.
        if (cnt_q == 4'd1) begin
          state_d = StDone;
          bcd_d   = stepped[ShW-1:BinW];
          ovf_d   = 1'b0;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Clr) begin
    if (Clr) begin
      state_q <= StIdle;
      sh_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);

`ifndef SYNTHESIS
  bcd_digits_valid: assert property (@(posedge clk) disable iff (Clr)
    (bcd_q[3:0] <= 4'd9) && (bcd_q[7:4] <= 4'd9) &&
    (bcd_q[11:8] <= 4'd9) && (bcd_q[15:12] <= 4'd9));

  done_single_cycle: assert property (@(posedge clk) disable iff (Clr)
    bus.done |=> !bus.done);
`endif

endmodule
